regfile_rename: RTL and testbench

REGFILE_RENAME -- requirements
Module: regfile_rename

---
 rtl/regfile_rename.sv | 139 +++++++++++++
 tb/tb_regfile_rename.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_rename.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_rename
//  Purpose  : Architectural register file with rename (busy/tag) tracking.
//             Dispatch marks a destination busy and records the producing ROB
//             tag. Commit writes the value and clears busy only when the
//             stored tag still matches. Flush clears every busy bit. The
//             busy-register population count is kept in a register.
//  Option   : REGFILE_CM_BYPASS_EN - forward a tag-matching commit to the
//             read ports in the same cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module regfile_rename #(
  parameter int DATA_W   = 32,
  parameter int REG_AW   = 5,
  parameter int TAG_W    = 4,
  parameter int RD_PORTS = 2
) (
  input  logic                       clk_in,
  input  logic                       rst_n_in,
  input  logic                       rdy_in,
  input  logic                       flush_in,
  input  logic [RD_PORTS*REG_AW-1:0] rd_addr_in,
  output logic [RD_PORTS-1:0]        rd_busy_out,
  output logic [RD_PORTS*DATA_W-1:0] rd_val_out,
  output logic [RD_PORTS*TAG_W-1:0]  rd_tag_out,
  input  logic                       dp_valid_in,
  input  logic [REG_AW-1:0]          dp_rd_in,
  input  logic [TAG_W-1:0]           dp_tag_in,
  input  logic                       cm_valid_in,
  input  logic [REG_AW-1:0]          cm_rd_in,
  input  logic [DATA_W-1:0]          cm_val_in,
  input  logic [TAG_W-1:0]           cm_tag_in,
  output logic [REG_AW:0]            busy_cnt_out
);

  localparam int c_REG_NUM = 2**REG_AW;

  // Architectural state; entry 0 is never written so it always reads zero.
  logic [DATA_W-1:0]    r_value [c_REG_NUM];
  logic [TAG_W-1:0]     r_tag   [c_REG_NUM];
  logic [c_REG_NUM-1:0] r_busy;
  logic [REG_AW:0]      r_busy_cnt;

  logic                 w_cm_en;
  logic                 w_dp_en;
  logic                 w_cm_hit;
  logic [c_REG_NUM-1:0] w_busy_nxt;
  logic [REG_AW:0]      w_cnt_nxt;

  // Qualified write enables; index 0 and a frozen pipeline suppress them,
  // and a flush cancels the dispatch but not the commit value write.
  always_comb begin
    w_cm_en  = rdy_in && cm_valid_in && (cm_rd_in != '0);
    w_dp_en  = rdy_in && dp_valid_in && !flush_in && (dp_rd_in != '0);
    w_cm_hit = w_cm_en && r_busy[cm_rd_in] && (r_tag[cm_rd_in] == cm_tag_in);
  end

  // Next busy vector: flush clears all, dispatch beats a same-index commit.
  always_comb begin
    w_busy_nxt = r_busy;
    if (rdy_in) begin
      if (flush_in) begin
        w_busy_nxt = '0;
      end else begin
        for (int i = 1; i < c_REG_NUM; i++) begin
          if (w_dp_en && (dp_rd_in == REG_AW'(i))) begin
            w_busy_nxt[i] = 1'b1;
          end else if (w_cm_hit && (cm_rd_in == REG_AW'(i))) begin
            w_busy_nxt[i] = 1'b0;
          end
        end
      end
    end
    w_busy_nxt[0] = 1'b0;
  end

  // Population count of the next busy vector, registered alongside it.
  always_comb begin
    w_cnt_nxt = '0;
    for (int i = 0; i < c_REG_NUM; i++) begin
      w_cnt_nxt = w_cnt_nxt + {{REG_AW{1'b0}}, w_busy_nxt[i]};
    end
  end

  // State update; everything holds while rdy_in is low.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_busy     <= '0;
      r_busy_cnt <= '0;
      for (int i = 0; i < c_REG_NUM; i++) begin
        r_value[i] <= '0;
        r_tag[i]   <= '0;
      end
    end else if (rdy_in) begin
      r_busy     <= w_busy_nxt;
      r_busy_cnt <= w_cnt_nxt;
      if (w_cm_en) begin
        r_value[cm_rd_in] <= cm_val_in;
      end
      if (w_dp_en) begin
        r_tag[dp_rd_in] <= dp_tag_in;
      end
    end
  end

  assign busy_cnt_out = r_busy_cnt;

  generate
    for (genvar p = 0; p < RD_PORTS; p++) begin : g_rd
      logic [REG_AW-1:0] w_addr;
      logic              w_busy;
      logic [DATA_W-1:0] w_val;
      logic [TAG_W-1:0]  w_tag;

      assign w_addr = rd_addr_in[p*REG_AW +: REG_AW];

      // Independent combinational read of stored state, optionally forwarding
      // a tag-matching commit that has not yet reached the array.
      always_comb begin
        w_busy = r_busy[w_addr];
        w_val  = r_value[w_addr];
        w_tag  = r_tag[w_addr];
`ifdef REGFILE_CM_BYPASS_EN
        if (w_cm_hit && (w_addr == cm_rd_in)) begin
          w_busy = 1'b0;
          w_val  = cm_val_in;
        end
`endif
      end

      assign rd_busy_out[p]              = w_busy;
      assign rd_val_out[p*DATA_W +: DATA_W] = w_val;
      assign rd_tag_out[p*TAG_W +: TAG_W]   = w_tag;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_regfile_rename.sv
`default_nettype none
// ============================================================================
//  Module   : tb_regfile_rename
//  Purpose  : Directed scoreboard bench for regfile_rename. Stimulus pushes
//             expected read-port / busy-count values; a monitor pops and
//             compares them on the falling clock edge.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_rename;

  localparam int DATA_W   = 32;
  localparam int REG_AW   = 5;
  localparam int TAG_W    = 4;
  localparam int RD_PORTS = 2;

  logic                       clk_in = 1'b0;
  logic                       rst_n_in;
  logic                       rdy_in;
  logic                       flush_in;
  logic [RD_PORTS*REG_AW-1:0] rd_addr_in;
  logic [RD_PORTS-1:0]        rd_busy_out;
  logic [RD_PORTS*DATA_W-1:0] rd_val_out;
  logic [RD_PORTS*TAG_W-1:0]  rd_tag_out;
  logic                       dp_valid_in;
  logic [REG_AW-1:0]          dp_rd_in;
  logic [TAG_W-1:0]           dp_tag_in;
  logic                       cm_valid_in;
  logic [REG_AW-1:0]          cm_rd_in;
  logic [DATA_W-1:0]          cm_val_in;
  logic [TAG_W-1:0]           cm_tag_in;
  logic [REG_AW:0]            busy_cnt_out;

  regfile_rename #(
    .DATA_W(DATA_W), .REG_AW(REG_AW), .TAG_W(TAG_W), .RD_PORTS(RD_PORTS)
  ) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in), .flush_in(flush_in),
    .rd_addr_in(rd_addr_in), .rd_busy_out(rd_busy_out), .rd_val_out(rd_val_out),
    .rd_tag_out(rd_tag_out), .dp_valid_in(dp_valid_in), .dp_rd_in(dp_rd_in),
    .dp_tag_in(dp_tag_in), .cm_valid_in(cm_valid_in), .cm_rd_in(cm_rd_in),
    .cm_val_in(cm_val_in), .cm_tag_in(cm_tag_in), .busy_cnt_out(busy_cnt_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    string             name;
    int                port;
    bit                is_cnt;
    logic              busy;
    logic [DATA_W-1:0] val;
    logic [TAG_W-1:0]  tag;
    logic [REG_AW:0]   cnt;
  } exp_t;

  exp_t sb[$];
  bit   done = 1'b0;
  int   checks = 0;
  int   errors = 0;

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle();
    dp_valid_in = 1'b0; dp_rd_in = '0; dp_tag_in = '0;
    cm_valid_in = 1'b0; cm_rd_in = '0; cm_val_in = '0; cm_tag_in = '0;
    flush_in = 1'b0;
  endtask

  task automatic dispatch(input logic [REG_AW-1:0] r, input logic [TAG_W-1:0] t);
    dp_valid_in = 1'b1; dp_rd_in = r; dp_tag_in = t;
  endtask

  task automatic commit(input logic [REG_AW-1:0] r, input logic [TAG_W-1:0] t,
                        input logic [DATA_W-1:0] v);
    cm_valid_in = 1'b1; cm_rd_in = r; cm_tag_in = t; cm_val_in = v;
  endtask

  task automatic exp_rd(input string nm, input int p, input logic [REG_AW-1:0] a,
                        input logic b, input logic [DATA_W-1:0] v,
                        input logic [TAG_W-1:0] t);
    exp_t e;
    rd_addr_in[p*REG_AW +: REG_AW] = a;
    e.name = nm; e.port = p; e.is_cnt = 1'b0;
    e.busy = b; e.val = v; e.tag = t; e.cnt = '0;
    sb.push_back(e);
  endtask

  task automatic exp_cnt(input string nm, input logic [REG_AW:0] c);
    exp_t e;
    e.name = nm; e.port = 0; e.is_cnt = 1'b1;
    e.busy = 1'b0; e.val = '0; e.tag = '0; e.cnt = c;
    sb.push_back(e);
  endtask

  // Monitor: drains the scoreboard on each falling edge, away from updates.
  initial begin : monitor
    exp_t e;
    int   cyc;
    logic              g_busy;
    logic [DATA_W-1:0] g_val;
    logic [TAG_W-1:0]  g_tag;
    cyc = 0;
    forever begin
      @(negedge clk_in);
      cyc++;
      while (sb.size() > 0) begin
        e = sb.pop_front();
        if (e.is_cnt) begin
          checks++;
          if (busy_cnt_out !== e.cnt) begin
            errors++;
            $display("FAIL %s busy_cnt got %0d want %0d", e.name, busy_cnt_out, e.cnt);
          end
        end else begin
          g_busy = rd_busy_out[e.port];
          g_val  = rd_val_out[e.port*DATA_W +: DATA_W];
          g_tag  = rd_tag_out[e.port*TAG_W +: TAG_W];
          checks++;
          if (g_busy !== e.busy) begin
            errors++;
            $display("FAIL %s busy got %0b want %0b", e.name, g_busy, e.busy);
          end
          checks++;
          if (g_val !== e.val) begin
            errors++;
            $display("FAIL %s value got %h want %h", e.name, g_val, e.val);
          end
          checks++;
          if (g_tag !== e.tag) begin
            errors++;
            $display("FAIL %s tag got %0d want %0d", e.name, g_tag, e.tag);
          end
        end
      end
      if (done || cyc > 5000) begin
        checks++;
        if (!done) begin
          errors++;
          $display("FAIL timeout got cycle %0d want stimulus done", cyc);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
      end
    end
  end

  initial begin : stim
    rst_n_in = 1'b0;
    rdy_in = 1'b1;
    rd_addr_in = '0;
    idle();
    repeat (3) @(posedge clk_in);
    #3 rst_n_in = 1'b1;
    step();
    exp_rd("init_x5", 0, 5'd5, 1'b0, 32'h0, 4'd0);
    exp_rd("init_x31", 1, 5'd31, 1'b0, 32'h0, 4'd0);
    exp_cnt("init_cnt", 6'd0);

    // Rename then commit
    dispatch(5'd5, 4'd3);
    step();
    idle();
    commit(5'd5, 4'd3, 32'hDEADBEEF);
`ifdef REGFILE_CM_BYPASS_EN
    exp_rd("rc_pre", 0, 5'd5, 1'b0, 32'hDEADBEEF, 4'd3);
`else
    exp_rd("rc_pre", 0, 5'd5, 1'b1, 32'h0, 4'd3);
`endif
    exp_cnt("rc_pre_cnt", 6'd1);
    step();
    idle();
    exp_rd("rc_post", 0, 5'd5, 1'b0, 32'hDEADBEEF, 4'd3);
    exp_cnt("rc_post_cnt", 6'd0);

    // Stale-tag commit
    dispatch(5'd7, 4'd2);
    step();
    dispatch(5'd7, 4'd6);
    step();
    idle();
    commit(5'd7, 4'd2, 32'h11);
    exp_rd("stale_pre", 1, 5'd7, 1'b1, 32'h0, 4'd6);
    step();
    idle();
    exp_rd("stale_post", 1, 5'd7, 1'b1, 32'h11, 4'd6);
    exp_cnt("stale_cnt", 6'd1);

    // Same-cycle commit and dispatch collision
    dispatch(5'd9, 4'd1);
    step();
    idle();
    commit(5'd9, 4'd1, 32'h22);
    dispatch(5'd9, 4'd4);
`ifdef REGFILE_CM_BYPASS_EN
    exp_rd("coll_pre", 0, 5'd9, 1'b0, 32'h22, 4'd1);
`else
    exp_rd("coll_pre", 0, 5'd9, 1'b1, 32'h0, 4'd1);
`endif
    step();
    idle();
    exp_rd("coll_post", 0, 5'd9, 1'b1, 32'h22, 4'd4);
    exp_cnt("coll_cnt", 6'd2);

    // Flush with concurrent dispatch and stale commit
    dispatch(5'd1, 4'd1); step();
    dispatch(5'd2, 4'd2); step();
    dispatch(5'd3, 4'd3); step();
    idle();
    exp_cnt("pre_flush_cnt", 6'd5);
    flush_in = 1'b1;
    dispatch(5'd4, 4'd5);
    commit(5'd5, 4'd0, 32'h55);
    step();
    idle();
    exp_rd("flush_x4", 0, 5'd4, 1'b0, 32'h0, 4'd0);
    exp_rd("flush_x7", 1, 5'd7, 1'b0, 32'h11, 4'd6);
    exp_cnt("flush_cnt", 6'd0);
    step();
    exp_rd("flush_x5", 0, 5'd5, 1'b0, 32'h55, 4'd3);
    exp_rd("flush_x1", 1, 5'd1, 1'b0, 32'h0, 4'd1);

    // Index zero ignored
    dispatch(5'd0, 4'd1);
    commit(5'd0, 4'd0, 32'hAB);
    step();
    idle();
    exp_rd("x0_p0", 0, 5'd0, 1'b0, 32'h0, 4'd0);
    exp_cnt("x0_cnt", 6'd0);

    // Matching commit, same-cycle visibility only with bypass
    dispatch(5'd5, 4'd10);
    step();
    idle();
    commit(5'd5, 4'd10, 32'h33);
`ifdef REGFILE_CM_BYPASS_EN
    exp_rd("byp_pre", 1, 5'd5, 1'b0, 32'h33, 4'd10);
`else
    exp_rd("byp_pre", 1, 5'd5, 1'b1, 32'h55, 4'd10);
`endif
    exp_cnt("byp_pre_cnt", 6'd1);
    step();
    idle();
    exp_rd("byp_post", 1, 5'd5, 1'b0, 32'h33, 4'd10);
    exp_cnt("byp_post_cnt", 6'd0);

    // rdy_in low freezes everything
    dispatch(5'd12, 4'd2);
    step();
    idle();
    rdy_in = 1'b0;
    flush_in = 1'b1;
    dispatch(5'd13, 4'd7);
    commit(5'd12, 4'd2, 32'h77);
    step();
    exp_rd("hold_x12", 0, 5'd12, 1'b1, 32'h0, 4'd2);
    exp_rd("hold_x13", 1, 5'd13, 1'b0, 32'h0, 4'd0);
    exp_cnt("hold_cnt", 6'd1);
    step();
    rdy_in = 1'b1;
    idle();

    // Asynchronous reset between edges, then clean restart
    rst_n_in = 1'b0;
    exp_rd("rst_x12", 0, 5'd12, 1'b0, 32'h0, 4'd0);
    exp_rd("rst_x5", 1, 5'd5, 1'b0, 32'h0, 4'd0);
    exp_cnt("rst_cnt", 6'd0);
    @(negedge clk_in);
    #2;
    rst_n_in = 1'b1;
    dispatch(5'd3, 4'd4);
    step();
    idle();
    exp_rd("rel_x3", 0, 5'd3, 1'b1, 32'h0, 4'd4);
    exp_cnt("rel_cnt", 6'd1);
    step();
    done = 1'b1;
  end

endmodule
`default_nettype wire
